// File: rtl/cla_pipelined_adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Used by all builds; the OVERFLOW_FLAG_EN option lives in the top.
package cla_pkg;

    localparam int SLICE_W = 4;

    // Control word that travels with every pipeline stage.
    typedef struct packed {
        logic vld;
        logic carry;
    } cla_ctrl_t;

    function automatic int cla_latency(input int width, input int sps);
        return (sps < 1) ? 1 : width / (SLICE_W * sps);
    endfunction

endpackage

// File: rtl/cla_pipelined_adder_if.sv
// Streaming operand/result bus of the pipelined CLA adder.
interface cla_pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/cla_pipelined_adder_group_stage.sv
// Combinational group of 4-bit CLA slices with group-level lookahead carries.
module cla_group_stage
    import cla_pkg::*;
#(
    parameter int SLICES = 2
) (
    input  logic [SLICE_W*SLICES-1:0] a,
    input  logic [SLICE_W*SLICES-1:0] b,
    input  logic                      cin,
    output logic [SLICE_W*SLICES-1:0] sum,
    output logic                      gp,
    output logic                      gg,
    output logic                      cout
);

    logic [SLICE_W*SLICES-1:0] p;
    logic [SLICE_W*SLICES-1:0] g;
    logic [SLICES-1:0]         sp;
    logic [SLICES-1:0]         sg;
    logic [SLICES:0]           c;
    logic                      bc;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        sp = '0;
        sg = '0;
        for (int j = 0; j < SLICES; j++) begin
            sp[j] = &p[j*SLICE_W +: SLICE_W];
            sg[j] = g[j*SLICE_W+3]
                  | (p[j*SLICE_W+3] & g[j*SLICE_W+2])
                  | (p[j*SLICE_W+3] & p[j*SLICE_W+2] & g[j*SLICE_W+1])
                  | (p[j*SLICE_W+3] & p[j*SLICE_W+2] & p[j*SLICE_W+1] & g[j*SLICE_W]);
        end
    end

    always_comb begin
        c    = '0;
        sum  = '0;
        bc   = 1'b0;
        c[0] = cin;
        for (int j = 0; j < SLICES; j++) begin
            c[j+1] = sg[j] | (sp[j] & c[j]);
        end
        // Inside a slice the carry is only needed for the sum bits.
        for (int j = 0; j < SLICES; j++) begin
            bc = c[j];
            for (int i = 0; i < SLICE_W; i++) begin
                sum[j*SLICE_W+i] = p[j*SLICE_W+i] ^ bc;
                bc               = g[j*SLICE_W+i] | (p[j*SLICE_W+i] & bc);
            end
        end
        gp = &sp;
        gg = 1'b0;
        for (int j = 0; j < SLICES; j++) begin
            gg = sg[j] | (sp[j] & gg);
        end
        cout = c[SLICES];
    end

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined CLA adder/subtractor, one group of slices resolved per stage.
// Optional macro OVERFLOW_FLAG_EN adds a signed-overflow flag aligned with out_sum.
module cla_pipelined_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int SLICES_PER_STAGE = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    cla_pipelined_adder_if.slave bus
);

    localparam int SW      = SLICE_W * SLICES_PER_STAGE;
    localparam int LATENCY = cla_latency(WIDTH, SLICES_PER_STAGE);

    if ((SLICES_PER_STAGE < 1) || (WIDTH % SW != 0)) begin : g_param_check
        $error("cla_pipelined_adder: WIDTH must be a multiple of 4*SLICES_PER_STAGE");
    end

    logic stall;
    logic advance;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stg
        localparam int OPW = WIDTH - k * SW;
        localparam int LO  = (k + 1) * SW;

        logic [OPW-1:0] a_in;
        logic [OPW-1:0] b_in;
        cla_ctrl_t      ctrl_in;
        cla_ctrl_t      ctrl_d;
        cla_ctrl_t      ctrl_q;
        logic [SW-1:0]  slice_sum;
        logic           grp_p;
        logic           grp_g;
        logic           grp_c;
        logic           grp_pg_unused;
        logic [LO-1:0]  sum_d;
        logic [LO-1:0]  sum_q;

        if (k == 0) begin : g_src
            always_comb begin
                a_in          = bus.in_a;
                b_in          = bus.in_sub ? ~bus.in_b : bus.in_b;
                ctrl_in.vld   = bus.in_valid;
                ctrl_in.carry = bus.in_sub | bus.in_cin;
                sum_d         = slice_sum;
            end
        end else begin : g_src
            always_comb begin
                a_in    = g_stg[k-1].g_fwd.a_q;
                b_in    = g_stg[k-1].g_fwd.b_q;
                ctrl_in = g_stg[k-1].ctrl_q;
                sum_d   = {slice_sum, g_stg[k-1].sum_q};
            end
        end

        cla_group_stage #(
            .SLICES(SLICES_PER_STAGE)
        ) u_grp (
            .a   (a_in[SW-1:0]),
            .b   (b_in[SW-1:0]),
            .cin (ctrl_in.carry),
            .sum (slice_sum),
            .gp  (grp_p),
            .gg  (grp_g),
            .cout(grp_c)
        );

        // Group P/G stay on the slice interface for external chaining; the stage uses cout.
        assign grp_pg_unused = grp_p ^ grp_g;

        always_comb begin
            ctrl_d.vld   = ctrl_in.vld;
            ctrl_d.carry = grp_c;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ctrl_q <= '0;
            end else if (advance) begin
                ctrl_q <= ctrl_d;
            end
        end

        always_ff @(posedge clk) begin
            if (advance) begin
                sum_q <= sum_d;
            end
        end

        if (k < LATENCY - 1) begin : g_fwd
            logic [OPW-SW-1:0] a_d;
            logic [OPW-SW-1:0] b_d;
            logic [OPW-SW-1:0] a_q;
            logic [OPW-SW-1:0] b_q;

            always_comb begin
                a_d = a_in[OPW-1:SW];
                b_d = b_in[OPW-1:SW];
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    always_comb begin
        stall   = g_stg[LATENCY-1].ctrl_q.vld & ~bus.out_ready;
        advance = ~stall;
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = g_stg[LATENCY-1].ctrl_q.vld;
    assign bus.out_sum   = g_stg[LATENCY-1].ctrl_q.vld ? g_stg[LATENCY-1].sum_q : '0;
    assign bus.out_cout  = g_stg[LATENCY-1].ctrl_q.vld & g_stg[LATENCY-1].ctrl_q.carry;

`ifdef OVERFLOW_FLAG_EN
    logic cmsb_d;
    logic cmsb_q;

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
    always_comb begin
        cmsb_d = g_stg[LATENCY-1].slice_sum[SW-1]
               ^ g_stg[LATENCY-1].a_in[SW-1]
               ^ g_stg[LATENCY-1].b_in[SW-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmsb_q <= 1'b0;
        end else if (advance) begin
            cmsb_q <= cmsb_d;
        end
    end

    assign bus.out_ovf = g_stg[LATENCY-1].ctrl_q.vld & (g_stg[LATENCY-1].ctrl_q.carry ^ cmsb_q);
`else
    assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Directed bench for cla_pipelined_adder (WIDTH=32, SLICES_PER_STAGE=2, latency 4).
// Overflow expectations follow OVERFLOW_FLAG_EN when the build defines it.
module tb_cla_pipelined_adder;

`ifdef OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cla_pipelined_adder_if #(.WIDTH(32)) bus ();

    cla_pipelined_adder #(
        .WIDTH           (32),
        .SLICES_PER_STAGE(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Drives one beat and watches the output for a bounded number of cycles.
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, output logic [31:0] sum, output logic cout,
                            output logic ovf, output int lat);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        lat  = -1;
        sum  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid && lat < 0) begin
                sum  = bus.out_sum;
                cout = bus.out_cout;
                ovf  = bus.out_ovf;
                lat  = c;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_sum !== 32'h0) begin failures++; $display("FAIL reset_out_sum got=%h want=00000000", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin failures++; $display("FAIL reset_out_cout got=%b want=0", bus.out_cout); end
        checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b want=0", bus.out_ovf); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed_vectors();
        logic [31:0] va [7] = '{32'hFFFFFFFF, 32'h00000005, 32'h00000007, 32'h00000007,
                                32'h12345678, 32'h0000FFFF, 32'h80000000};
        logic [31:0] vb [7] = '{32'h00000001, 32'h00000007, 32'h00000005, 32'h00000005,
                                32'h11111111, 32'h00000000, 32'h80000000};
        logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        vs [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] es [7] = '{32'h00000000, 32'hFFFFFFFE, 32'h00000002, 32'h00000002,
                                32'h2345678A, 32'h00010000, 32'h00000000};
        logic        ec [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            run_beat(va[i], vb[i], vc[i], vs[i], sum, cout, ovf, lat);
            checks++; if (lat !== 4) begin failures++; $display("FAIL vec%0d_latency got=%0d want=4", i, lat); end
            checks++; if (sum !== es[i]) begin failures++; $display("FAIL vec%0d_sum got=%h want=%h", i, sum, es[i]); end
            checks++; if (cout !== ec[i]) begin failures++; $display("FAIL vec%0d_cout got=%b want=%b", i, cout, ec[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] va [3] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000001};
        logic [31:0] vb [3] = '{32'h00000001, 32'h00000001, 32'h00000001};
        logic        vs [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] es [3] = '{32'h80000000, 32'h7FFFFFFF, 32'h00000002};
        logic        eo [3] = '{OVF_EN, OVF_EN, 1'b0};
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_beat(va[i], vb[i], 1'b0, vs[i], sum, cout, ovf, lat);
            checks++; if (sum !== es[i]) begin failures++; $display("FAIL ovf%0d_sum got=%h want=%h", i, sum, es[i]); end
            checks++; if (ovf !== eo[i]) begin failures++; $display("FAIL ovf%0d_flag got=%b want=%b", i, ovf, eo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [31:0] exp_s;
        bus.out_ready = 1'b1;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            exp_v = (c >= 4) && (c <= 11);
            exp_s = exp_v ? 32'(4 * (c - 4)) : 32'h0;
            checks++; if (bus.out_valid !== exp_v) begin failures++; $display("FAIL stream_valid cycle=%0d got=%b want=%b", c, bus.out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (bus.out_sum !== exp_s) begin failures++; $display("FAIL stream_sum cycle=%0d got=%h want=%h", c, bus.out_sum, exp_s); end
            end
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cycle=%0d got=%b want=1", c, bus.in_ready); end
            bus.in_valid = (c < 8);
            bus.in_a     = 32'(c);
            bus.in_b     = 32'(3 * c);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        logic [31:0] want;
        int          ptr;
        int          got;
        ptr = 0;
        got = 0;
        bus.in_cin = 1'b0;
        bus.in_sub = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus.in_valid  = (ptr < 6);
            bus.in_a      = 32'(100 + ptr);
            bus.in_b      = 32'(ptr);
            bus.out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (cyc >= 4 && cyc <= 6) begin
                checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cycle=%0d got=%b want=0", cyc, bus.in_ready); end
                checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid cycle=%0d got=%b want=1", cyc, bus.out_valid); end
                checks++; if (bus.out_sum !== 32'd100) begin failures++; $display("FAIL stall_out_sum cycle=%0d got=%h want=%h", cyc, bus.out_sum, 32'd100); end
                checks++; if (bus.out_cout !== 1'b0) begin failures++; $display("FAIL stall_out_cout cycle=%0d got=%b want=0", cyc, bus.out_cout); end
            end
            if (bus.out_valid && bus.out_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                checks++; if (bus.out_sum !== want) begin failures++; $display("FAIL bp_order beat=%0d got=%h want=%h", got, bus.out_sum, want); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(32'(100 + 2 * ptr));
                ptr++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (got !== 6) begin failures++; $display("FAIL bp_received got=%0d want=6", got); end
        checks++; if (ptr !== 6) begin failures++; $display("FAIL bp_accepted got=%0d want=6", ptr); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_duplicate got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b1;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'(10 + i);
            bus.in_b     = 32'(1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_sum !== 32'h0) begin failures++; $display("FAIL midreset_sum got=%h want=00000000", bus.out_sum); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_stale cycle=%0d got=%b want=0", c, bus.out_valid); end
        end
    endtask

    initial begin
        clk      = 1'b0;
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed_vectors();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
